// File: rtl/tri_job_sched_if.sv
// Job/engine/completion bundle for tri_job_sched.
// master = job source + engine model side, slave = the scheduler.
interface tri_job_sched_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 7
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             job_valid;
  logic             job_ready;
  logic [17:0]      job_data;
  logic             eng_busy;
  logic             eng_po;
  logic             eng_nt;
  logic [2:0]       eng_xi;
  logic [2:0]       eng_yi;
  logic             done;
  logic [CNT_W-1:0] done_pix;
  logic             done_tmo;
  logic [CW-1:0]    fifo_cnt;
  logic             idle;

  modport master (
    output job_valid, job_data, eng_busy, eng_po,
    input  job_ready, eng_nt, eng_xi, eng_yi,
    input  done, done_pix, done_tmo, fifo_cnt, idle
  );

  modport slave (
    input  job_valid, job_data, eng_busy, eng_po,
    output job_ready, eng_nt, eng_xi, eng_yi,
    output done, done_pix, done_tmo, fifo_cnt, idle
  );
endinterface

// File: rtl/tri_job_sched.sv
// Triangle job scheduler: FIFO of 3-vertex jobs, drives the engine's
// nt/xi/yi load, tracks busy/po and reports done + pixel count.
// Ports: clk, reset (sync, active-high), bus (tri_job_sched_if.slave).
module tri_job_sched #(
  parameter int DEPTH    = 4,
  parameter int CNT_W    = 7,
  parameter int BUSY_TMO = 4
) (
  input  logic             clk,
  input  logic             reset,
  tri_job_sched_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(BUSY_TMO + 1);
  localparam logic [CNT_W-1:0] PIX_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_V1, S_V2, S_V3, S_WAIT, S_RUN, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [17:0]      mem_q [DEPTH];
  logic [17:0]      mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [17:0]      job_q, job_d;
  logic [CNT_W-1:0] pix_q, pix_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             nt_q, nt_d;
  logic [2:0]       xi_q, xi_d;
  logic [2:0]       yi_q, yi_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] done_pix_q, done_pix_d;
  logic             done_tmo_q, done_tmo_d;
  logic             ready_q, ready_d;
  logic             idle_q, idle_d;
  logic             push, pop, tmo_hit;
  logic [5:0]       vtx;

  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    job_d      = job_q;
    pix_d      = pix_q;
    tmo_d      = tmo_q;
    done_pix_d = done_pix_q;
    pop        = 1'b0;
    tmo_hit    = 1'b0;
    push       = bus.job_valid && ready_q;

    unique case (state_q)
      S_IDLE: begin
        if (cnt_q != '0 && !bus.eng_busy) begin
          pop     = 1'b1;
          job_d   = mem_q[rd_q];
          state_d = S_V1;
        end
      end
      S_V1: state_d = S_V2;
      S_V2: state_d = S_V3;
      S_V3: begin
        pix_d   = '0;
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tmo_d = tmo_q + TW'(1);
        if (bus.eng_busy) begin
          state_d = S_RUN;
        end else if (tmo_d == TW'(BUSY_TMO)) begin
          tmo_hit = 1'b1;
          state_d = S_DONE;
        end
      end
      S_RUN: begin
        if (!bus.eng_busy) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // po counts in WAIT/RUN only, including the cycle busy falls
    if ((state_q == S_WAIT || state_q == S_RUN) &&
        bus.eng_po && pix_q != PIX_MAX) begin
      pix_d = pix_q + CNT_W'(1);
    end

    if (push) begin
      mem_d[wr_q] = bus.job_data;
      wr_d        = wr_q + AW'(1);
    end
    if (pop) rd_d = rd_q + AW'(1);
    if (push && !pop) cnt_d = cnt_q + CW'(1);
    if (pop && !push) cnt_d = cnt_q - CW'(1);

    // outputs are registered from next state so they line up with it
    unique case (state_d)
      S_V1:    vtx = job_d[17:12];
      S_V2:    vtx = job_d[11:6];
      S_V3:    vtx = job_d[5:0];
      default: vtx = '0;
    endcase
    xi_d = vtx[5:3];
    yi_d = vtx[2:0];
    nt_d = (state_d == S_V1);

    done_d     = (state_d == S_DONE);
    done_tmo_d = tmo_hit;
    if (done_d) done_pix_d = pix_d;

    ready_d = (cnt_d < CW'(DEPTH));
    idle_d  = (state_d == S_IDLE) && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      state_q    <= S_IDLE;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      job_q      <= '0;
      pix_q      <= '0;
      tmo_q      <= '0;
      nt_q       <= 1'b0;
      xi_q       <= '0;
      yi_q       <= '0;
      done_q     <= 1'b0;
      done_pix_q <= '0;
      done_tmo_q <= 1'b0;
      ready_q    <= 1'b1;
      idle_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      job_q      <= job_d;
      pix_q      <= pix_d;
      tmo_q      <= tmo_d;
      nt_q       <= nt_d;
      xi_q       <= xi_d;
      yi_q       <= yi_d;
      done_q     <= done_d;
      done_pix_q <= done_pix_d;
      done_tmo_q <= done_tmo_d;
      ready_q    <= ready_d;
      idle_q     <= idle_d;
    end
  end

  assign bus.job_ready = ready_q;
  assign bus.eng_nt    = nt_q;
  assign bus.eng_xi    = xi_q;
  assign bus.eng_yi    = yi_q;
  assign bus.done      = done_q;
  assign bus.done_pix  = done_pix_q;
  assign bus.done_tmo  = done_tmo_q;
  assign bus.fifo_cnt  = cnt_q;
  assign bus.idle      = idle_q;
endmodule

// File: doc/tri_job_sched.md
Name: tri_job_sched

Overview:
- Job scheduler in front of the triangle rendering engine.
- Buffers triangle jobs (three 3-bit vertices each) in a small FIFO and drives the engine's 3-cycle vertex load protocol (nt/xi/yi) whenever the engine is not busy.
- Tracks each render to completion, counts the engine's po pixel strobes, and reports per-triangle completion with a pixel count.
- Sits between the host/job source and the triangle engine; shares the engine's clk and reset.

Parameters:
- DEPTH, 4: job FIFO entries, power of 2, ≥2.
- CNT_W, 7: pixel counter width; 8x8 grid gives at most 64 pixels.
- BUSY_TMO, 4: cycles to wait for eng_busy to rise after the third vertex before the job is declared degenerate.

Ports:
- clk  in  1: clock, rising edge.
- reset  in  1: synchronous, active-high reset; shared with the engine.
- job_valid  in  1: job offered.
- job_ready  out  1: FIFO can accept; equals count<DEPTH.
- job_data  in  18: [17:12]=v1, [11:6]=v2, [5:0]=v3; each vertex is {x[5:3],y[2:0]} of its 6-bit field.
- eng_busy  in  1: engine busy.
- eng_po  in  1: engine pixel-out strobe.
- eng_nt  out  1: new-triangle strobe to engine.
- eng_xi  out  3: vertex x to engine.
- eng_yi  out  3: vertex y to engine.
- done  out  1: one-cycle pulse, triangle finished.
- done_pix  out  CNT_W: pixel count of finished triangle; valid while done=1, held until next done.
- done_tmo  out  1: with done, job timed out (busy never rose).
- fifo_cnt  out  log2(DEPTH)+1: FIFO occupancy.
- idle  out  1: state IDLE and FIFO empty.

Behaviour:
- Synchronous, active-high reset. All outputs are registered.
- Reset values: eng_nt=0, eng_xi=0, eng_yi=0, done=0, done_pix=0, done_tmo=0, fifo_cnt=0, job_ready=1, idle=1, state=IDLE.
- FIFO:
  - Push on job_valid&&job_ready.
  - Pop only on the IDLE->V1 transition.
  - A push when full is impossible, since ready=0. No same-cycle bypass.
  - Simultaneous push and pop leaves fifo_cnt unchanged.
  - Pointers wrap modulo DEPTH.
- State machine, all transitions on the clk rising edge:
  - IDLE: if fifo_cnt!=0 and eng_busy==0, pop the head into the job register and go to V1. Otherwise stay.
  - V1: eng_nt=1, xi/yi=v1. Go to V2.
  - V2: eng_nt=0, xi/yi=v2. Go to V3.
  - V3: xi/yi=v3. Clear the pixel counter and the timeout counter. Go to WAIT.
  - WAIT: xi/yi=0. Increment the timeout counter. If eng_busy=1, go to RUN. Else if the timeout counter reaches BUSY_TMO, go to DONE with tmo flag=1.
  - RUN: when eng_busy=0, go to DONE.
  - DONE: done=1, done_pix=counter, done_tmo=flag. Go to IDLE.
- Outside V1-V3, eng_xi/eng_yi=0 and eng_nt=0.
- Latency:
  - A job accepted at edge T into an empty FIFO while IDLE produces eng_nt=1 in the cycle after edge T+1.
  - Back-to-back jobs: at least 1 IDLE cycle between DONE and the next V1.
- Pixel count:
  - Increments on every cycle with eng_po=1 while in WAIT or RUN.
  - eng_po in the same cycle that busy falls is still counted.
  - Saturates at 2^CNT_W-1; no wrap.
  - eng_po in IDLE/V1-V3/DONE is ignored.
- eng_busy rising during V1-V3 is ignored; its level is sampled only in IDLE/WAIT/RUN.
- A reset mid-render flushes the FIFO and discards the job. No done is issued. Next cycle eng_nt=0 and state=IDLE.

Test Plan:
- Single job:
  - Stimulus: job_data={v1=6'o12, v2=6'o53, v3=6'o16}. Model engine raises busy 1 cycle after V3, gives 5 po pulses, then drops busy.
  - Required response: eng_nt high exactly 1 cycle; xi/yi sequence 1/2, 5/3, 1/6 on consecutive cycles. One done pulse with done_pix=5, done_tmo=0.
- FIFO full:
  - Stimulus: push 5 jobs back-to-back with the engine held busy=1.
  - Required response: job_ready drops after 4 accepts, fifo_cnt=4, the 5th is not accepted, and no eng_nt fires. After busy release, the jobs are issued in push order.
- Push and pop same cycle:
  - Stimulus: fifo_cnt=2 and a push coincides with IDLE->V1.
  - Required response: fifo_cnt stays 2.
- Timeout:
  - Stimulus: engine never raises busy.
  - Required response: done asserts exactly BUSY_TMO cycles after entering WAIT, with done_tmo=1 and done_pix=0.
- Saturation:
  - Stimulus: CNT_W=3, engine emits 10 po pulses.
  - Required response: done_pix=7.
- Mid-render reset:
  - Stimulus: assert reset for 1 cycle in RUN with 2 jobs queued.
  - Required response: after reset, fifo_cnt=0, idle=1, eng_nt=0, and no done pulse is issued.
